// File: rtl/prg_fetch_bridge.sv
// PRG bus to SDRAM user-port bridge: resynchronizes the CPU bus and issues one request per new stable access.
// Optional write forwarding is enabled by defining PRG_WRITE_EN.
module prg_fetch_bridge #(
  parameter logic [5:0] ADDR_HI = 6'h00
) (
  input  logic        clk_sdram,
  input  logic        rst,
  input  logic        prg_nce_in,
  input  logic [14:0] prg_a_in,
  input  logic        prg_r_nw_in,
  input  logic [7:0]  prg_d_in,
  output logic [7:0]  prg_d_out,
  output logic        boot_done,
  output logic        busy,
  output logic [20:0] mem_address,
  output logic [7:0]  to_mem,
  output logic        mem_req,
  output logic        mem_wren,
  input  logic        mem_ready,
  input  logic [7:0]  from_mem
);

  typedef struct packed {
    logic        nce;
    logic        r_nw;
    logic [14:0] a;
    logic [7:0]  d;
  } bus_t;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_REQ,
    ST_WAIT0,
    ST_WAIT
  } state_t;

  localparam bus_t BUS_RST = {1'b1, 1'b0, 15'h0000, 8'h00};

  bus_t        s1_q, s2_q, s3_q;
  state_t      state_q;
  logic        boot_done_q;
  logic        mem_req_q;
  logic [14:0] addr_q;
  logic [7:0]  data_q;
  logic [15:0] last_key_q;
  logic        key_valid_q;
`ifdef PRG_WRITE_EN
  logic        wren_q;
  logic [7:0]  wdata_q;
`endif

  logic        stable;
  logic        wr_ok;
  logic [15:0] key;
  logic        issue;

  always_ff @(posedge clk_sdram) begin
    if (rst) begin
      s1_q <= BUS_RST;
      s2_q <= BUS_RST;
      s3_q <= BUS_RST;
    end else begin
      s1_q <= {prg_nce_in, prg_r_nw_in, prg_a_in, prg_d_in};
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    stable = (s2_q == s3_q);
    key    = {s2_q.r_nw, s2_q.a};
`ifdef PRG_WRITE_EN
    wr_ok  = 1'b1;
`else
    wr_ok  = s2_q.r_nw;
`endif
    issue  = stable && !s2_q.nce && wr_ok && (!key_valid_q || (key != last_key_q));
  end

  always_ff @(posedge clk_sdram) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      boot_done_q <= 1'b0;
      mem_req_q   <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      last_key_q  <= '0;
      key_valid_q <= 1'b0;
`ifdef PRG_WRITE_EN
      wren_q      <= 1'b0;
      wdata_q     <= '0;
`endif
    end else begin
      mem_req_q <= 1'b0;
      case (state_q)
        ST_BOOT: begin
          if (mem_ready) begin
            boot_done_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (issue) begin
            addr_q      <= s2_q.a;
`ifdef PRG_WRITE_EN
            wren_q      <= ~s2_q.r_nw;
            wdata_q     <= s2_q.d;
`endif
            last_key_q  <= key;
            key_valid_q <= 1'b1;
            // strobe is registered here so it is high for exactly the REQ cycle
            mem_req_q   <= 1'b1;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ:   state_q <= ST_WAIT0;
        ST_WAIT0: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (mem_ready) begin
            if (!mem_wren) data_q <= from_mem;
            state_q <= ST_IDLE;
          end
        end
        default:  state_q <= ST_BOOT;
      endcase
    end
  end

`ifdef PRG_WRITE_EN
  assign mem_wren = wren_q;
  assign to_mem   = wdata_q;
`else
  assign mem_wren = 1'b0;
  assign to_mem   = '0;
`endif

  assign mem_req     = mem_req_q;
  assign boot_done   = boot_done_q;
  assign busy        = (state_q == ST_REQ) || (state_q == ST_WAIT0) || (state_q == ST_WAIT);
  assign mem_address = {ADDR_HI, addr_q};
  assign prg_d_out   = data_q & {8{~s2_q.nce}};

endmodule

// File: tb/tb_prg_fetch_bridge.sv
// Directed bench for prg_fetch_bridge with a request scoreboard; define PRG_WRITE_EN to match the RTL build.
module tb_prg_fetch_bridge;

  logic        clk_sdram;
  logic        rst;
  logic        prg_nce_in;
  logic [14:0] prg_a_in;
  logic        prg_r_nw_in;
  logic [7:0]  prg_d_in;
  logic [7:0]  prg_d_out;
  logic        boot_done;
  logic        busy;
  logic [20:0] mem_address;
  logic [7:0]  to_mem;
  logic        mem_req;
  logic        mem_wren;
  logic        mem_ready;
  logic [7:0]  from_mem;

  typedef struct {
    logic [20:0] addr;
    logic        wren;
    logic [7:0]  wd;
  } req_t;

  req_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   req_seen = 0;
  int   exp_cnt = 0;
  logic req_prev = 1'b0;

  prg_fetch_bridge #(.ADDR_HI(6'h00)) dut (
    .clk_sdram   (clk_sdram),
    .rst         (rst),
    .prg_nce_in  (prg_nce_in),
    .prg_a_in    (prg_a_in),
    .prg_r_nw_in (prg_r_nw_in),
    .prg_d_in    (prg_d_in),
    .prg_d_out   (prg_d_out),
    .boot_done   (boot_done),
    .busy        (busy),
    .mem_address (mem_address),
    .to_mem      (to_mem),
    .mem_req     (mem_req),
    .mem_wren    (mem_wren),
    .mem_ready   (mem_ready),
    .from_mem    (from_mem)
  );

  initial begin
    clk_sdram = 1'b0;
    forever #5 clk_sdram = ~clk_sdram;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [20:0] a, input logic w, input logic [7:0] d);
    req_t r;
    r.addr = a;
    r.wren = w;
    r.wd   = d;
    exp_q.push_back(r);
    exp_cnt++;
  endtask

  task automatic step();
    @(posedge clk_sdram);
    #1;
  endtask

  // returns at the negedge inside the REQ cycle; lat counts negedges waited
  task automatic wait_req(input string tag, input int budget, output int lat);
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk_sdram);
      if (mem_req === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk(tag, 32'(lat != 0), 32'd1);
  endtask

  task automatic serve(input int lat, input logic [7:0] rd);
    @(posedge clk_sdram);
    #1;
    mem_ready = 1'b0;
    repeat (lat) step();
    from_mem  = rd;
    mem_ready = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk_sdram);
    @(negedge clk_sdram);
  endtask

  always @(negedge clk_sdram) begin
    if (mem_req === 1'b1) begin
      req_t r;
      req_seen++;
      chk("req_single", 32'(req_prev), 32'd0);
      chk("req_busy", 32'(busy), 32'd1);
      chk("req_after_boot", 32'(boot_done), 32'd1);
      chk("req_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        chk("req_addr", 32'(mem_address), 32'(r.addr));
        chk("req_wren", 32'(mem_wren), 32'(r.wren));
        chk("req_wdata", 32'(to_mem), 32'(r.wd));
      end
    end
    req_prev = mem_req;
  end

  initial begin
    int lat;
    rst         = 1'b1;
    prg_nce_in  = 1'b1;
    prg_a_in    = '0;
    prg_r_nw_in = 1'b1;
    prg_d_in    = '0;
    mem_ready   = 1'b0;
    from_mem    = '0;

    // reset state
    repeat (3) step();
    @(negedge clk_sdram);
    chk("rst_boot_done", 32'(boot_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_wren", 32'(mem_wren), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'h0);
    chk("rst_to_mem", 32'(to_mem), 32'd0);
    chk("rst_prg_d_out", 32'(prg_d_out), 32'd0);

    // boot waits for ready
    step();
    rst = 1'b0;
    repeat (20) step();
    chk("boot_wait", 32'(boot_done), 32'd0);
    mem_ready = 1'b1;
    @(negedge clk_sdram);
    chk("boot_not_yet", 32'(boot_done), 32'd0);
    settle();
    chk("boot_done", 32'(boot_done), 32'd1);
    chk("boot_no_req", 32'(req_seen), 32'd0);
    chk("boot_d_out", 32'(prg_d_out), 32'd0);

    // first read, latency and hold
    step();
    prg_a_in   = 15'h7FFC;
    prg_nce_in = 1'b0;
    push(21'h007FFC, 1'b0, 8'h00);
    wait_req("rd1_timeout", 20, lat);
    chk("rd1_latency", 32'(lat), 32'd5);
    serve(2, 8'hA5);
    settle();
    chk("rd1_data", 32'(prg_d_out), 32'hA5);
    repeat (50) step();
    chk("rd1_hold_no_req", 32'(req_seen), 32'(exp_cnt));
    chk("rd1_idle_busy", 32'(busy), 32'd0);

    // address changes during WAIT: only the latest key is fetched
    prg_a_in = 15'h0200;
    push(21'h000200, 1'b0, 8'h00);
    wait_req("rd2_timeout", 20, lat);
    @(posedge clk_sdram);
    #1;
    mem_ready = 1'b0;
    step();
    prg_a_in = 15'h0300;
    repeat (3) step();
    prg_a_in = 15'h0010;
    push(21'h000010, 1'b0, 8'h00);
    repeat (6) step();
    from_mem  = 8'h77;
    mem_ready = 1'b1;
    settle();
    chk("rd2_data", 32'(prg_d_out), 32'h77);
    wait_req("rd3_timeout", 20, lat);
    serve(1, 8'h3C);
    settle();
    chk("rd3_data", 32'(prg_d_out), 32'h3C);
    repeat (10) step();
    chk("rd3_req_count", 32'(req_seen), 32'(exp_cnt));

    // write
    prg_a_in    = 15'h0123;
    prg_r_nw_in = 1'b0;
    prg_d_in    = 8'h5A;
`ifdef PRG_WRITE_EN
    push(21'h000123, 1'b1, 8'h5A);
    wait_req("wr_timeout", 20, lat);
    serve(1, 8'hEE);
    settle();
`else
    repeat (20) step();
`endif
    chk("wr_d_out_kept", 32'(prg_d_out), 32'h3C);
    repeat (5) step();
    chk("wr_req_count", 32'(req_seen), 32'(exp_cnt));

    // reset during WAIT, then refetch of the same address
    prg_a_in    = 15'h0040;
    prg_r_nw_in = 1'b1;
    prg_d_in    = 8'h00;
    push(21'h000040, 1'b0, 8'h00);
    wait_req("rd4_timeout", 20, lat);
    @(posedge clk_sdram);
    #1;
    mem_ready = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    @(negedge clk_sdram);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    settle();
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_boot", 32'(boot_done), 32'd0);
    chk("midrst_d_out", 32'(prg_d_out), 32'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("midrst_still_boot", 32'(boot_done), 32'd0);
    mem_ready = 1'b1;
    push(21'h000040, 1'b0, 8'h00);
    wait_req("rd5_timeout", 20, lat);
    serve(1, 8'h99);
    settle();
    chk("rd5_data", 32'(prg_d_out), 32'h99);

    // nce high: no requests, output forced to zero
    step();
    prg_nce_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      prg_a_in = 15'(i * 15'h0111);
      repeat (5) step();
      @(negedge clk_sdram);
      chk("nce_hi_d_out", 32'(prg_d_out), 32'd0);
    end
    step();
    prg_a_in = 15'h0040;
    repeat (5) step();
    prg_nce_in = 1'b0;
    repeat (10) step();
    @(negedge clk_sdram);
    chk("nce_reassert_d_out", 32'(prg_d_out), 32'h99);
    chk("nce_req_count", 32'(req_seen), 32'(exp_cnt));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
